// File: rtl/register_pkg.sv
// Shared encodings for the multi-mode datapath register: shift modes and
// the controller state type.
package register_pkg;

  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift1_unit.sv
// Combinational one-bit shifter used both by the single-step sr/sl path and
// by each step of the multi-cycle shift. Mode 11 behaves as logical.
module shift1_unit
  import register_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] val_i,
  input  logic         dir_i,
  input  logic [1:0]   mode_i,
  input  logic         fill_i,
  output logic [W-1:0] res_o,
  output logic         bit_o
);

  always_comb begin
    res_o = val_i;
    bit_o = 1'b0;
    if (!dir_i) begin
      bit_o = val_i[0];
      case (mode_i)
        MODE_ARI: res_o = {val_i[W-1], val_i[W-1:1]};
        MODE_ROT: res_o = {val_i[0], val_i[W-1:1]};
        default:  res_o = {fill_i, val_i[W-1:1]};
      endcase
    end else begin
      bit_o = val_i[W-1];
      case (mode_i)
        MODE_ARI: res_o = {val_i[W-2:0], 1'b0};
        MODE_ROT: res_o = {val_i[W-2:0], val_i[W-1]};
        default:  res_o = {val_i[W-2:0], fill_i};
      endcase
    end
  end

endmodule

// File: rtl/multi_mode_register.sv
// General datapath register: clear/load/count/shift with selectable shift
// modes, saturating counting and a multi-cycle shift-by-N with busy/done.
//   state    | meaning
//   ST_IDLE  | accepts one op per edge (cl > ld > start > inc > dec > sr > sl)
//   ST_SHIFT | busy, one latched-direction shift per edge; only cl is honoured
//   ST_DONE  | done pulse for one cycle; ops accepted as in ST_IDLE
module multi_mode_register
  import register_pkg::*;
#(
  parameter int W   = 8,
  parameter int SHW = $clog2(W + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cl_i,
  input  logic           ld_i,
  input  logic [W-1:0]   in_i,
  input  logic           inc_i,
  input  logic           dec_i,
  input  logic           sr_i,
  input  logic           ir_i,
  input  logic           sl_i,
  input  logic           il_i,
  input  logic [1:0]     mode_i,
  input  logic           sat_i,
  input  logic           start_i,
  input  logic           dir_i,
  input  logic [SHW-1:0] shamt_i,
  output logic [W-1:0]   out_o,
  output logic           carry_o,
  output logic           zero_o,
  output logic           busy_o,
  output logic           done_o
);

  state_t         state_q, state_d;
  logic [W-1:0]   out_q, out_d;
  logic           carry_q, carry_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic           sdir_q, sdir_d;
  logic [1:0]     smode_q, smode_d;
  logic           sfill_q, sfill_d;

  logic           sh_dir, sh_fill, sh_bit;
  logic [1:0]     sh_mode;
  logic [W-1:0]   sh_res;
  logic [SHW-1:0] shamt_c;

  assign shamt_c = (shamt_i > SHW'(W)) ? SHW'(W) : shamt_i;

  shift1_unit #(.W(W)) u_shift (
    .val_i  (out_q),
    .dir_i  (sh_dir),
    .mode_i (sh_mode),
    .fill_i (sh_fill),
    .res_o  (sh_res),
    .bit_o  (sh_bit)
  );

  // The shifter is steered by the live inputs in idle and by the latched
  // controls while a multi-shift is running.
  always_comb begin
    sh_dir  = ~sr_i;
    sh_mode = mode_i;
    sh_fill = sr_i ? ir_i : il_i;
    if (state_q == ST_SHIFT) begin
      sh_dir  = sdir_q;
      sh_mode = smode_q;
      sh_fill = sfill_q;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sdir_d  = sdir_q;
    smode_d = smode_q;
    sfill_d = sfill_q;
    case (state_q)
      ST_SHIFT: begin
        if (cl_i) begin
          out_d   = '0;
          carry_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          out_d   = sh_res;
          carry_d = sh_bit;
          cnt_d   = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (cl_i) begin
          out_d   = '0;
          carry_d = 1'b0;
        end else if (ld_i) begin
          out_d   = in_i;
          carry_d = 1'b0;
        end else if (start_i) begin
          sdir_d  = dir_i;
          smode_d = mode_i;
          sfill_d = dir_i ? il_i : ir_i;
          cnt_d   = shamt_c;
          state_d = (shamt_c == '0) ? ST_DONE : ST_SHIFT;
        end else if (inc_i) begin
          carry_d = (out_q == '1);
          if (!(sat_i && out_q == '1)) out_d = out_q + 1'b1;
        end else if (dec_i) begin
          carry_d = (out_q == '0);
          if (!(sat_i && out_q == '0)) out_d = out_q - 1'b1;
        end else if (sr_i || sl_i) begin
          out_d   = sh_res;
          carry_d = sh_bit;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sdir_q  <= 1'b0;
      smode_q <= MODE_LOG;
      sfill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sdir_q  <= sdir_d;
      smode_q <= smode_d;
      sfill_q <= sfill_d;
    end
  end

  assign out_o   = out_q;
  assign carry_o = carry_q;
  assign zero_o  = (out_q == '0);
  assign busy_o  = (state_q == ST_SHIFT);
  assign done_o  = (state_q == ST_DONE);

endmodule
